seg_display_scan: RTL and testbench
===================================

Name: seg_display_scan

Overview:
- Parametrised N-digit multiplexed seven-segment driver for the DDR game board; next generation of the lives/arrow display driver.
- Adds a real digit scan, an arrow mode latched on each metronome beat, a lives mode, a number mode with a sequential binary-to-BCD converter, and per-digit blinking.
- Sits between the game FSM (mode, arrows, lives, score) and the board seg/an pins.

Parameters:
- NUM_DIGITS, 4, number of digits/anodes (≥2).
- CODE_BITS, 5, width of one symbol code.
- VALUE_BITS, 14, width of the number-mode binary input.
- REFRESH_DIV, 50000, clk cycles each digit stays lit (≥2).
- BLINK_DIV, 12500000, clk cycles per blink half-period (≥2).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- metronome_clk  in  1  beat square wave, asynchronous to clk.
- mode  in  2  0=ARROW, 1=LIVES, 2=NUMBER, 3=BLANK.
- digit_codes  in  NUM_DIGITS*CODE_BITS  arrow-mode symbols; slice i belongs to digit i.
- lives  in  3  lives count.
- value  in  VALUE_BITS  number-mode binary value.
- load_value  in  1  one-cycle pulse; start conversion of value.
- blink_mask  in  NUM_DIGITS  bit i set = digit i blinks.
- seg  out  7  segments, active-low, registered.
- an  out  NUM_DIGITS  anodes, active-low one-hot, registered; an[0] = rightmost digit.
- busy  out  1  high while a BCD conversion runs.

Behaviour:
- Reset (rst=1 at a clk edge):
  - seg = 7'b1111111 and an = all ones.
  - busy = 0; scan index, refresh, blink and beat registers = 0.
  - All display registers = CODE_BLANK.
- Beat detect:
  - metronome_clk passes through 3 flops.
  - beat = 1 for exactly one clk when the two oldest stages are 0 then 1.
  - Latency from the input rise is 3 clk cycles.
- ARROW mode: on beat, display reg i <= digit_codes slice i for all i. Registers hold between beats.
- LIVES mode:
  - Every cycle, reg 0 <= digit code of lives (0..7); all other regs <= CODE_BLANK.
- NUMBER mode:
  - load_value with busy=0 captures value and sets busy.
  - Double-dabble runs one shift per cycle for VALUE_BITS cycles. busy clears VALUE_BITS+1 cycles after load_value.
  - On completion, the BCD digits are written to the display regs in the same cycle.
  - Leading zeros are blanked; digit 0 always shows, so value 0 displays "0".
  - If value > 10^NUM_DIGITS-1, all digits show 9 (saturate).
  - load_value while busy is ignored. Display regs keep the old number until completion.
- BLANK mode: all regs <= CODE_BLANK.
- Mode change:
  - Any cycle where mode differs from its registered copy loads all regs with CODE_BLANK and aborts any conversion (busy <= 0).
  - Mode change beats a simultaneous beat or conversion completion.
- Scan:
  - Refresh counter counts 0..REFRESH_DIV-1.
  - On wrap, scan index <= (index+1) mod NUM_DIGITS.
  - an and seg are updated in the same clk edge, so a digit never shows its neighbour's segments.
- Decode:
  - Codes 0-9 → digits.
  - 10-13 → up/down/left/right arrows.
  - 14-19 → combo arrows.
  - 20 and all undefined codes → blank (7'h7F).
- Blink:
  - blink_phase toggles every BLINK_DIV cycles.
  - When blink_phase=1 and blink_mask[index]=1, seg = 7'h7F; an is still driven normally.
- rst mid-conversion aborts it; all outputs return to reset values on the next edge.

Decomposition:
- Shared ddr_definitions include holds:
  - SEG_* segment constants, including the arrow patterns.
  - CODE_* symbol values, including CODE_BLANK=20.
  - MODE_* encodings.
- One sub-module: bin_to_bcd_seq.
  - Parameters VALUE_BITS, NUM_DIGITS.
  - Ports clk, rst, start, bin, busy, done, bcd, overflow.
  - Serial double-dabble.
- Scan, blink, beat detect and decode stay in the top module.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, BLINK_DIV=16):
- Reset then release, mode=BLANK → seg=7'h7F, an=4'b1111 on the first cycle. After that, an cycles 1110→1101→1011→0111 every 4 clk, and seg stays 7'h7F.
- ARROW, digit_codes={10,11,12,13}, metronome rise → regs unchanged before the beat; 3 cycles after the rise, regs = {10,11,12,13}. Changing digit_codes between beats has no effect.
- LIVES, lives=5 → while an=1110, seg=SEG_FIVE; other digits blank.
- NUMBER, load_value with value=407 → busy high for 14 cycles. Digits then read " 407". A second load during busy is ignored.
- NUMBER, value=12000 → all digits show 9. value=0 → only digit 0 lit with SEG_ZERO.
- blink_mask=4'b0001 in LIVES → digit 0 is blank during blink_phase=1 and lit during phase 0. Mode switch to ARROW with a simultaneous beat → all blank until the next beat.

Source files
------------

// File: rtl/seg_display_scan_pkg.sv
// Shared display definitions: segment patterns (active-low, bit order gfedcba),
// symbol codes, mode encodings and the code-to-segment decoder.
package seg_display_scan_pkg;

   typedef enum logic [1:0] {
      MODE_ARROW  = 2'd0,
      MODE_LIVES  = 2'd1,
      MODE_NUMBER = 2'd2,
      MODE_BLANK  = 2'd3
   } mode_e;

   localparam logic [6:0] SEG_ZERO  = 7'h40;
   localparam logic [6:0] SEG_ONE   = 7'h79;
   localparam logic [6:0] SEG_TWO   = 7'h24;
   localparam logic [6:0] SEG_THREE = 7'h30;
   localparam logic [6:0] SEG_FOUR  = 7'h19;
   localparam logic [6:0] SEG_FIVE  = 7'h12;
   localparam logic [6:0] SEG_SIX   = 7'h02;
   localparam logic [6:0] SEG_SEVEN = 7'h78;
   localparam logic [6:0] SEG_EIGHT = 7'h00;
   localparam logic [6:0] SEG_NINE  = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [6:0] SEG_UP    = 7'b0011100;
   localparam logic [6:0] SEG_DOWN  = 7'b0100011;
   localparam logic [6:0] SEG_LEFT  = 7'b0001111;
   localparam logic [6:0] SEG_RIGHT = 7'b0111001;
   // Combos light the union of both arrows; active-low, so union is AND.
   localparam logic [6:0] SEG_UP_DOWN    = SEG_UP & SEG_DOWN;
   localparam logic [6:0] SEG_LEFT_RIGHT = SEG_LEFT & SEG_RIGHT;
   localparam logic [6:0] SEG_UP_LEFT    = SEG_UP & SEG_LEFT;
   localparam logic [6:0] SEG_UP_RIGHT   = SEG_UP & SEG_RIGHT;
   localparam logic [6:0] SEG_DOWN_LEFT  = SEG_DOWN & SEG_LEFT;
   localparam logic [6:0] SEG_DOWN_RIGHT = SEG_DOWN & SEG_RIGHT;

   localparam logic [7:0] CODE_ZERO       = 8'd0;
   localparam logic [7:0] CODE_NINE       = 8'd9;
   localparam logic [7:0] CODE_UP         = 8'd10;
   localparam logic [7:0] CODE_DOWN       = 8'd11;
   localparam logic [7:0] CODE_LEFT       = 8'd12;
   localparam logic [7:0] CODE_RIGHT      = 8'd13;
   localparam logic [7:0] CODE_UP_DOWN    = 8'd14;
   localparam logic [7:0] CODE_LEFT_RIGHT = 8'd15;
   localparam logic [7:0] CODE_UP_LEFT    = 8'd16;
   localparam logic [7:0] CODE_UP_RIGHT   = 8'd17;
   localparam logic [7:0] CODE_DOWN_LEFT  = 8'd18;
   localparam logic [7:0] CODE_DOWN_RIGHT = 8'd19;
   localparam logic [7:0] CODE_BLANK      = 8'd20;

   function automatic logic [6:0] seg_decode(input logic [7:0] code);
      case (code)
         8'd0:            return SEG_ZERO;
         8'd1:            return SEG_ONE;
         8'd2:            return SEG_TWO;
         8'd3:            return SEG_THREE;
         8'd4:            return SEG_FOUR;
         8'd5:            return SEG_FIVE;
         8'd6:            return SEG_SIX;
         8'd7:            return SEG_SEVEN;
         8'd8:            return SEG_EIGHT;
         8'd9:            return SEG_NINE;
         CODE_UP:         return SEG_UP;
         CODE_DOWN:       return SEG_DOWN;
         CODE_LEFT:       return SEG_LEFT;
         CODE_RIGHT:      return SEG_RIGHT;
         CODE_UP_DOWN:    return SEG_UP_DOWN;
         CODE_LEFT_RIGHT: return SEG_LEFT_RIGHT;
         CODE_UP_LEFT:    return SEG_UP_LEFT;
         CODE_UP_RIGHT:   return SEG_UP_RIGHT;
         CODE_DOWN_LEFT:  return SEG_DOWN_LEFT;
         CODE_DOWN_RIGHT: return SEG_DOWN_RIGHT;
         default:         return SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/seg_display_scan_if.sv
// Game-FSM side of the display driver: mode/content inputs and pin outputs.
interface seg_display_scan_if #(
   parameter int NUM_DIGITS = 4,
   parameter int CODE_BITS  = 5,
   parameter int VALUE_BITS = 14
);
   logic [1:0]                      mode;
   logic [NUM_DIGITS*CODE_BITS-1:0] digit_codes;
   logic [2:0]                      lives;
   logic [VALUE_BITS-1:0]           value;
   logic                            load_value;
   logic [NUM_DIGITS-1:0]           blink_mask;
   logic [6:0]                      seg;
   logic [NUM_DIGITS-1:0]           an;
   logic                            busy;

   modport master (output mode, digit_codes, lives, value, load_value, blink_mask,
                   input  seg, an, busy);
   modport slave  (input  mode, digit_codes, lives, value, load_value, blink_mask,
                   output seg, an, busy);
endinterface

// File: rtl/seg_display_scan_bin_to_bcd_seq.sv
// Serial double-dabble: one shift per cycle. done/bcd/overflow are valid in the
// final busy cycle so the caller can latch the result on the edge busy clears.
module bin_to_bcd_seq #(
   parameter int VALUE_BITS = 14,
   parameter int NUM_DIGITS = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [VALUE_BITS-1:0]   bin,
   output logic                    busy,
   output logic                    done,
   output logic [NUM_DIGITS*4-1:0] bcd,
   output logic                    overflow
);
   // Every 3 binary bits need at most one decimal digit; keep at least one spare
   // digit above the display so overflow is always observable.
   localparam int FIT = (VALUE_BITS + 2) / 3;
   localparam int BD  = (FIT > NUM_DIGITS) ? FIT : NUM_DIGITS + 1;
   localparam int CW  = $clog2(VALUE_BITS + 1);

   logic [VALUE_BITS-1:0] sreg;
   logic [BD*4-1:0]       acc, adj, acc_nxt;
   logic [CW-1:0]         cnt;

   always_comb begin
      adj = acc;
      for (int d = 0; d < BD; d++)
         if (acc[d*4 +: 4] >= 4'd5) adj[d*4 +: 4] = acc[d*4 +: 4] + 4'd3;
      acc_nxt = {adj[BD*4-2:0], sreg[VALUE_BITS-1]};
   end

   assign done     = busy && (cnt == CW'(1));
   assign bcd      = acc_nxt[NUM_DIGITS*4-1:0];
   assign overflow = adj[BD*4-1] | (|acc_nxt[BD*4-1:NUM_DIGITS*4]);

   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= 1'b0;
         cnt  <= '0;
         sreg <= '0;
         acc  <= '0;
      end else if (start && !busy) begin
         sreg <= bin;
         acc  <= '0;
         cnt  <= CW'(VALUE_BITS);
         busy <= 1'b1;
      end else if (busy) begin
         sreg <= sreg << 1;
         acc  <= acc_nxt;
         cnt  <= cnt - CW'(1);
         if (cnt == CW'(1)) busy <= 1'b0;
      end
   end
endmodule

// File: rtl/seg_display_scan.sv
// N-digit multiplexed seven-segment driver: beat-latched arrows, lives,
// BCD number display, per-digit blink, and the anode scan.
module seg_display_scan
   import seg_display_scan_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int CODE_BITS   = 5,
   parameter int VALUE_BITS  = 14,
   parameter int REFRESH_DIV = 50000,
   parameter int BLINK_DIV   = 12500000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              metronome_clk,
   seg_display_scan_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam int RW    = $clog2(REFRESH_DIV);
   localparam int BW    = $clog2(BLINK_DIV);
   localparam logic [CODE_BITS-1:0] BLANK_C = CODE_BITS'(CODE_BLANK);

   logic [2:0]                           beat_pipe;
   logic                                 beat, mode_chg, lead;
   mode_e                                mode, mode_q;
   logic [NUM_DIGITS-1:0][CODE_BITS-1:0] disp, num_codes;
   logic [IDX_W-1:0]                     idx;
   logic [RW-1:0]                        ref_cnt;
   logic [BW-1:0]                        blink_cnt;
   logic                                 blink_phase;
   logic                                 conv_start, conv_done, conv_ovf;
   logic [NUM_DIGITS*4-1:0]              conv_bcd;

   assign mode       = mode_e'(bus.mode);
   assign mode_chg   = (mode != mode_q);
   assign beat       = beat_pipe[1] & ~beat_pipe[2];
   assign conv_start = bus.load_value && (mode == MODE_NUMBER) && !mode_chg;

   // A mode change aborts a running conversion through the converter's reset.
   bin_to_bcd_seq #(.VALUE_BITS(VALUE_BITS), .NUM_DIGITS(NUM_DIGITS)) u_bcd (
      .clk      (clk),
      .rst      (rst | mode_chg),
      .start    (conv_start),
      .bin      (bus.value),
      .busy     (bus.busy),
      .done     (conv_done),
      .bcd      (conv_bcd),
      .overflow (conv_ovf)
   );

   // Leading-zero blanking walks from the top digit; digit 0 always shows.
   always_comb begin
      lead      = 1'b1;
      num_codes = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         if (conv_ovf) begin
            num_codes[i] = CODE_BITS'(CODE_NINE);
         end else begin
            if (conv_bcd[i*4 +: 4] != 4'd0 || i == 0) lead = 1'b0;
            num_codes[i] = lead ? BLANK_C : CODE_BITS'(conv_bcd[i*4 +: 4]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         beat_pipe   <= '0;
         mode_q      <= MODE_BLANK;
         disp        <= {NUM_DIGITS{BLANK_C}};
         idx         <= '0;
         ref_cnt     <= '0;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
         bus.seg     <= SEG_BLANK;
         bus.an      <= '1;
      end else begin
         beat_pipe <= {beat_pipe[1:0], metronome_clk};
         mode_q    <= mode;

         if (mode_chg) begin
            disp <= {NUM_DIGITS{BLANK_C}};
         end else begin
            case (mode)
               MODE_ARROW:  if (beat) disp <= bus.digit_codes;
               MODE_LIVES: begin
                  disp    <= {NUM_DIGITS{BLANK_C}};
                  disp[0] <= CODE_BITS'(bus.lives);
               end
               MODE_NUMBER: if (conv_done) disp <= num_codes;
               default:     disp <= {NUM_DIGITS{BLANK_C}};
            endcase
         end

         if (ref_cnt == RW'(REFRESH_DIV - 1)) begin
            ref_cnt <= '0;
            idx     <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
         end else begin
            ref_cnt <= ref_cnt + RW'(1);
         end

         if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + BW'(1);
         end

         // an and seg come from the same idx so they always change together.
         bus.an  <= ~(NUM_DIGITS'(1) << idx);
         bus.seg <= (blink_phase && bus.blink_mask[idx]) ? SEG_BLANK
                                                         : seg_decode(8'(disp[idx]));
      end
   end
endmodule

// File: tb/tb_seg_display_scan.sv
// Directed bench: expected display frames are queued when stimulus is driven
// and compared against one full anode scan of the DUT.
module tb_seg_display_scan;
   import seg_display_scan_pkg::*;

   localparam int ND = 4, CB = 5, VB = 14;
   localparam logic [6:0] DIGS [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                        7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
   localparam logic [6:0] BL = 7'h7F;

   logic clk = 1'b0, rst = 1'b1, metronome_clk = 1'b0;
   int   cyc, n_chk = 0, n_pass = 0, n_fail = 0;
   logic [27:0] sb [$];

   seg_display_scan_if #(.NUM_DIGITS(ND), .CODE_BITS(CB), .VALUE_BITS(VB)) dif ();

   seg_display_scan #(.NUM_DIGITS(ND), .CODE_BITS(CB), .VALUE_BITS(VB),
                      .REFRESH_DIV(4), .BLINK_DIV(16)) dut (
      .clk(clk), .rst(rst), .metronome_clk(metronome_clk), .bus(dif));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick(int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scan model: sample taken after edge c shows the digit selected before it.
   function automatic logic [3:0] an_of(int c);
      logic [3:0] one = 4'b0001;
      return ~(one << (((c - 1) / 4) % 4));
   endfunction

   function automatic int phase_of(int c);
      return ((c - 1) / 16) % 2;
   endfunction

   function automatic logic [27:0] frame(logic [6:0] d3, logic [6:0] d2,
                                         logic [6:0] d1, logic [6:0] d0);
      return {d3, d2, d1, d0};
   endfunction

   task automatic capture(string tag);
      logic [27:0] exp;
      logic [6:0]  got  [4];
      bit          seen [4];
      logic [3:0]  one = 4'b0001;
      int          n = 0;
      exp = sb.pop_front();
      for (int i = 0; i < 4; i++) begin got[i] = 'x; seen[i] = 1'b0; end
      for (int c = 0; c < 40 && n < 4; c++) begin
         tick();
         for (int d = 0; d < 4; d++)
            if (!seen[d] && dif.an === ~(one << d)) begin
               got[d] = dif.seg; seen[d] = 1'b1; n++;
            end
      end
      for (int d = 0; d < 4; d++)
         chk($sformatf("%s digit%0d", tag, d), 32'(got[d]), 32'(exp[d*7 +: 7]));
   endtask

   task automatic run_num(int v, logic [27:0] ef, string tag);
      int n = 0;
      dif.value = VB'(v); dif.load_value = 1'b1;
      tick();
      dif.load_value = 1'b0;
      sb.push_back(ef);
      while (dif.busy === 1'b1 && n < 40) begin n++; tick(); end
      chk({tag, " busy cycles"}, 32'(n), 32'd14);
      capture(tag);
   endtask

   initial begin
      int n;
      logic [6:0] aexp [4];
      dif.mode = 2'd3; dif.digit_codes = '0; dif.lives = '0; dif.value = '0;
      dif.load_value = 1'b0; dif.blink_mask = '0;

      tick(3);
      chk("reset seg", 32'(dif.seg), 32'h7F);
      chk("reset an", 32'(dif.an), 32'hF);
      chk("reset busy", 32'(dif.busy), 32'd0);
      rst = 1'b0;
      for (int k = 1; k <= 17; k++) begin
         tick();
         if ((k - 1) % 4 == 0) begin
            chk($sformatf("scan an k=%0d", k), 32'(dif.an), 32'(an_of(cyc)));
            chk($sformatf("scan seg k=%0d", k), 32'(dif.seg), 32'h7F);
         end
      end

      dif.mode = 2'd1; dif.lives = 3'd5;
      tick(3);
      sb.push_back(frame(BL, BL, BL, DIGS[5]));
      capture("lives5");
      dif.lives = 3'd7;
      tick(2);
      sb.push_back(frame(BL, BL, BL, DIGS[7]));
      capture("lives7");

      dif.lives = 3'd5; dif.blink_mask = 4'b0001;
      tick(2);
      for (int k = 0; k < 64; k++) begin
         tick();
         if (an_of(cyc) == 4'b1110 && (cyc - 1) % 4 == 1) begin
            chk("blink an", 32'(dif.an), 32'hE);
            chk($sformatf("blink seg phase%0d", phase_of(cyc)), 32'(dif.seg),
                32'(phase_of(cyc) == 1 ? BL : DIGS[5]));
         end
      end
      dif.blink_mask = '0;

      dif.mode = 2'd0; dif.digit_codes = {5'd10, 5'd11, 5'd12, 5'd13};
      aexp = '{SEG_RIGHT, SEG_LEFT, SEG_DOWN, SEG_UP};
      tick(4);
      metronome_clk = 1'b1;
      tick(3);
      chk("arrow before beat", 32'(dif.seg), 32'h7F);
      tick();
      chk("arrow after beat", 32'(dif.seg), 32'(aexp[((cyc - 1) / 4) % 4]));
      dif.digit_codes = {5'd1, 5'd2, 5'd3, 5'd4};
      tick(2);
      sb.push_back(frame(SEG_UP, SEG_DOWN, SEG_LEFT, SEG_RIGHT));
      capture("arrow hold");

      metronome_clk = 1'b0; dif.mode = 2'd1;
      tick(5);
      dif.digit_codes = {5'd14, 5'd15, 5'd16, 5'd17};
      metronome_clk = 1'b1;
      tick(2);
      dif.mode = 2'd0;
      tick(3);
      sb.push_back(frame(BL, BL, BL, BL));
      capture("switch with beat");
      metronome_clk = 1'b0;
      tick(3);
      metronome_clk = 1'b1;
      tick(5);
      sb.push_back(frame(SEG_UP_DOWN, SEG_LEFT_RIGHT, SEG_UP_LEFT, SEG_UP_RIGHT));
      capture("combo");
      metronome_clk = 1'b0;
      tick(3);
      dif.digit_codes = {5'd18, 5'd19, 5'd20, 5'd31};
      metronome_clk = 1'b1;
      tick(5);
      sb.push_back(frame(SEG_DOWN_LEFT, SEG_DOWN_RIGHT, BL, BL));
      capture("combo undefined");

      dif.mode = 2'd2;
      tick(2);
      dif.value = VB'(407); dif.load_value = 1'b1;
      tick();
      dif.load_value = 1'b0;
      sb.push_back(frame(BL, DIGS[4], DIGS[0], DIGS[7]));
      n = 0;
      while (dif.busy === 1'b1 && n < 40) begin
         n++;
         if (n == 3) begin dif.value = VB'(1234); dif.load_value = 1'b1; end
         else dif.load_value = 1'b0;
         tick();
      end
      chk("num407 busy cycles", 32'(n), 32'd14);
      capture("num407");

      run_num(12000, frame(DIGS[9], DIGS[9], DIGS[9], DIGS[9]), "num12000");
      run_num(0, frame(BL, BL, BL, DIGS[0]), "num0");
      run_num(10000, frame(DIGS[9], DIGS[9], DIGS[9], DIGS[9]), "num10000");
      run_num(1005, frame(DIGS[1], DIGS[0], DIGS[0], DIGS[5]), "num1005");

      dif.value = VB'(407); dif.load_value = 1'b1;
      tick();
      dif.load_value = 1'b0;
      tick(3);
      dif.mode = 2'd3;
      tick();
      chk("abort busy", 32'(dif.busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
